// File: rtl/cp0_defs.sv
// CP0 shared definitions: register numbers, SR/CAUSE field positions, FSM encoding.
package cp0_defs;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;

   localparam int SR_IE        = 0;
   localparam int SR_IM_LSB    = 1;
   localparam int CAUSE_ID_LSB = 8;
   localparam int CAUSE_ID_W   = 3;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ENTER   = 2'd1;
   localparam logic [1:0] S_SERVICE = 2'd2;
   localparam logic [1:0] S_RETURN  = 2'd3;

endpackage

// File: rtl/irq_edge_latch.sv
// Per-line rising-edge detector with pending flop (set beats clear).
// Optional 2-flop input synchronizer when IRQ_SYNC_EN is defined.
module irq_edge_latch (
   input  logic clk,
   input  logic rst,
   input  logic irq,
   input  logic clr,
   output logic pending
);

   logic irq_s;
   logic prev;

`ifdef IRQ_SYNC_EN
   logic s1, s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= irq;
         s2 <= s1;
      end
   end

   assign irq_s = s2;
`else
   assign irq_s = irq;
`endif

   // prev tracks the line even in reset so a held-high line is not an edge
   always_ff @(posedge clk) begin
      prev <= irq_s;
      if (rst)
         pending <= 1'b0;
      else if (irq_s && !prev)
         pending <= 1'b1;
      else if (clr)
         pending <= 1'b0;
   end

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt sequencer: SR/CAUSE/EPC, priority pick, entry/return redirect.
// Define IRQ_SYNC_EN to add a 2-flop synchronizer on each irq line.
module cp0_int_ctrl
   import cp0_defs::*;
#(
   parameter int          NUM_IRQ    = 3,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0040
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               boundary,
   input  logic [31:0]        pc_i,
   input  logic               mtc0,
   input  logic               mfc0,
   input  logic               eret,
   input  logic [4:0]         cp0_sel,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               redirect,
   output logic               flush,
   output logic [31:0]        vec_pc,
   output logic               in_service
);

   logic [1:0]            state, st, nxt;
   logic [NUM_IRQ-1:0]    pending, mask, hit, clr;
   logic                  ie, take, ret, unused_ok;
   logic [CAUSE_ID_W-1:0] cause_id, win;
   logic [31:0]           epc, sr_val, cause_val;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
      irq_edge_latch u_latch (
         .clk     (clk),
         .rst     (rst),
         .irq     (irq[g]),
         .clr     (clr[g]),
         .pending (pending[g])
      );
   end

   assign hit  = pending & mask;
   assign take = !rst && state == S_IDLE && ie && |hit && boundary;
   assign ret  = !rst && state == S_RETURN;

   always_comb begin
      win = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (hit[i]) win = CAUSE_ID_W'(i);
   end

   always_comb begin
      clr = '0;
      for (int i = 0; i < NUM_IRQ; i++)
         clr[i] = take && win == CAUSE_ID_W'(i);
   end

   // ENTER is the IDLE cycle in which the interrupt is accepted
   assign st = take ? S_ENTER : state;

   always_comb begin
      nxt = S_IDLE;
      unique case (1'b1)
         st == S_ENTER:   nxt = S_SERVICE;
         st == S_SERVICE: nxt = eret ? S_RETURN : S_SERVICE;
         default:         nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         ie       <= 1'b0;
         mask     <= '0;
         cause_id <= '0;
         epc      <= '0;
      end else begin
         state <= nxt;
         if (mtc0 && cp0_sel == CP0_SR) begin
            ie   <= wdata[SR_IE];
            mask <= wdata[SR_IM_LSB +: NUM_IRQ];
         end
         if (mtc0 && cp0_sel == CP0_CAUSE)
            cause_id <= wdata[CAUSE_ID_LSB +: CAUSE_ID_W];
         if (mtc0 && cp0_sel == CP0_EPC)
            epc <= wdata;
         if (st == S_ENTER) begin
            ie       <= 1'b0;
            epc      <= pc_i;
            cause_id <= win;
         end
         if (st == S_RETURN)
            ie <= 1'b1;
      end
   end

   assign redirect   = take || ret;
   assign flush      = take;
   assign in_service = state == S_SERVICE;

   always_comb begin
      vec_pc = '0;
      if (take)
         vec_pc = VEC_BASE + 32'(win) * VEC_STRIDE;
      else if (ret)
         vec_pc = epc;
   end

   always_comb begin
      sr_val = '0;
      sr_val[SR_IE] = ie;
      sr_val[SR_IM_LSB +: NUM_IRQ] = mask;
      cause_val = '0;
      cause_val[NUM_IRQ-1:0] = pending;
      cause_val[CAUSE_ID_LSB +: CAUSE_ID_W] = cause_id;
      rdata = '0;
      if (mfc0) begin
         unique case (1'b1)
            cp0_sel == CP0_SR:    rdata = sr_val;
            cp0_sel == CP0_CAUSE: rdata = cause_val;
            cp0_sel == CP0_EPC:   rdata = epc;
            default:              rdata = '0;
         endcase
      end
   end

   assign unused_ok = ^wdata;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Bench for cp0_int_ctrl: directed scenarios then random traffic,
// all cycles checked against a behavioural CP0 model.
module tb_cp0_int_ctrl;

   localparam int          N      = 3;
   localparam logic [31:0] BASE   = 32'h0000_0800;
   localparam logic [31:0] STRIDE = 32'h0000_0040;

   logic          clk = 1'b0;
   logic          rst, boundary, mtc0, mfc0, eret;
   logic [N-1:0]  irq;
   logic [31:0]   pc_i, wdata, rdata, vec_pc;
   logic [4:0]    cp0_sel;
   logic          redirect, flush, in_service;

   always #5 clk = ~clk;

   cp0_int_ctrl #(.NUM_IRQ(N), .VEC_BASE(BASE), .VEC_STRIDE(STRIDE)) dut (
      .clk        (clk),
      .rst        (rst),
      .irq        (irq),
      .boundary   (boundary),
      .pc_i       (pc_i),
      .mtc0       (mtc0),
      .mfc0       (mfc0),
      .eret       (eret),
      .cp0_sel    (cp0_sel),
      .wdata      (wdata),
      .rdata      (rdata),
      .redirect   (redirect),
      .flush      (flush),
      .vec_pc     (vec_pc),
      .in_service (in_service)
   );

   int total = 0;
   int bad   = 0;

   // model: mode 0 = waiting, 1 = handler running, 2 = returning
   int          m_mode = 0;
   bit          m_ie   = 0;
   bit [N-1:0]  m_mask = '0, m_pend = '0, m_prev = '0;
   int          m_id   = 0;
   logic [31:0] m_epc  = '0;

   logic        s_red, s_flush, s_isv;
   logic [31:0] s_vec, s_rd;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      int          win;
      bit          take, back;
      bit [N-1:0]  hit, rise;
      logic [31:0] e_vec, e_rd;
      #2;
      s_red = redirect; s_flush = flush; s_vec = vec_pc;
      s_rd = rdata; s_isv = in_service;
      hit = m_pend & m_mask;
      win = -1;
      for (int i = 0; i < N; i++)
         if (hit[i] && win < 0) win = i;
      take = !rst && m_mode == 0 && m_ie && boundary && win >= 0;
      back = !rst && m_mode == 2;
      e_vec = 0;
      if (take) e_vec = BASE + win * STRIDE;
      else if (back) e_vec = m_epc;
      e_rd = 0;
      if (mfc0) begin
         case (cp0_sel)
            5'd12:   e_rd = {28'd0, m_mask, m_ie};
            5'd13:   e_rd = (32'(m_id) << 8) | 32'(m_pend);
            5'd14:   e_rd = m_epc;
            default: e_rd = 0;
         endcase
      end
      chk("redirect", redirect, 32'(take || back));
      chk("flush", flush, 32'(take));
      chk("vec_pc", vec_pc, e_vec);
      chk("in_service", in_service, 32'(m_mode == 1));
      chk("rdata", rdata, e_rd);
      if (rst) begin
         m_mode = 0; m_ie = 0; m_mask = '0; m_pend = '0;
         m_id = 0; m_epc = '0; m_prev = irq;
      end else begin
         rise = irq & ~m_prev;
         m_prev = irq;
         if (take) m_pend[win] = 1'b0;
         m_pend |= rise;
         if (mtc0) begin
            case (cp0_sel)
               5'd12: {m_mask, m_ie} = wdata[N:0];
               5'd13: m_id = int'(wdata[10:8]);
               5'd14: m_epc = wdata;
               default: ;
            endcase
         end
         if (take) begin
            m_epc = pc_i; m_ie = 0; m_id = win;
         end
         if (m_mode == 2) m_ie = 1;
         if (take) m_mode = 1;
         else if (m_mode == 1 && eret) m_mode = 2;
         else if (m_mode == 2) m_mode = 0;
      end
      @(negedge clk);
      mtc0 = 0; mfc0 = 0; eret = 0;
   endtask

   task automatic wr(input logic [4:0] s, input logic [31:0] d);
      mtc0 = 1; cp0_sel = s; wdata = d;
      tick();
   endtask

   task automatic rd(input logic [4:0] s);
      mfc0 = 1; cp0_sel = s;
      tick();
   endtask

   task automatic er();
      eret = 1;
      tick();
   endtask

   initial begin
      rst = 1; irq = '0; boundary = 1; pc_i = 32'h100;
      mtc0 = 0; mfc0 = 0; eret = 0; cp0_sel = '0; wdata = '0;
      @(negedge clk);
      tick(); tick();
      rst = 0;
      rd(5'd12); chk("rst_sr", s_rd, 0);
      rd(5'd13); chk("rst_cause", s_rd, 0);
      rd(5'd14); chk("rst_epc", s_rd, 0);
      chk("rst_red", s_red, 0);
      chk("rst_isv", s_isv, 0);

      wr(5'd12, 32'h3);
      tick(); tick();
      irq = 3'b001; tick();
      tick();
      chk("t1_red", s_red, 1);
      chk("t1_flush", s_flush, 1);
      chk("t1_vec", s_vec, 32'h800);
      rd(5'd14); chk("t1_epc", s_rd, 32'h100);
      chk("t1_isv", s_isv, 1);
      rd(5'd12); chk("t1_sr", s_rd, 32'h2);

      er();
      tick();
      chk("t2_red", s_red, 1);
      chk("t2_flush", s_flush, 0);
      chk("t2_vec", s_vec, 32'h100);
      rd(5'd12); chk("t2_sr", s_rd, 32'h3);
      chk("t2_isv", s_isv, 0);

      irq = '0; wr(5'd12, 32'hF);
      irq = 3'b110; tick();
      tick(); chk("t3_vec1", s_vec, 32'h840);
      er(); tick();
      tick(); chk("t3_red2", s_red, 1);
      chk("t3_vec2", s_vec, 32'h880);
      er(); tick();

      rst = 1; irq = '0; tick();
      rst = 0; wr(5'd12, 32'h1);
      irq = 3'b001; tick();
      rd(5'd13); chk("t4_cause", s_rd, 32'h1);
      chk("t4_nored", s_red, 0);
      wr(5'd12, 32'h3);
      tick(); chk("t4_red", s_red, 1);
      chk("t4_vec", s_vec, 32'h800);
      er(); tick();

      er(); chk("t5_eret_idle", s_red, 0);
      irq = '0; tick();
      boundary = 0; irq = 3'b001; tick();
      for (int i = 0; i < 5; i++) begin
         tick(); chk("t5_stall", s_red, 0);
      end
      boundary = 1; tick(); chk("t5_red", s_red, 1);
      er(); tick();

      irq = '0; tick();
      irq = 3'b001; tick();
      tick(); tick(); chk("t6_isv", s_isv, 1);
      rst = 1; tick();
      rst = 0; tick(); chk("t6_isv0", s_isv, 0);
      rd(5'd12); chk("t6_sr", s_rd, 0);
      wr(5'd12, 32'h3);
      for (int i = 0; i < 3; i++) begin
         tick(); chk("t6_held", s_red, 0);
      end
      rd(5'd13); chk("t6_cause", s_rd, 0);

      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
         boundary = ($urandom_range(0, 3) != 0);
         pc_i = $urandom;
         mtc0 = ($urandom_range(0, 7) == 0);
         mfc0 = $urandom_range(0, 1) == 1;
         eret = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 3))
            0:       cp0_sel = 5'd12;
            1:       cp0_sel = 5'd13;
            2:       cp0_sel = 5'd14;
            default: cp0_sel = 5'($urandom);
         endcase
         wdata = $urandom;
         if ($urandom_range(0, 3) != 0) wdata[0] = 1'b1;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
